// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Sequencer states: idle, low-byte access, high-byte access, capture.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_CAP  = 2'd3
    } lsu_state_e;

    // Access size encodings carried on req_size_i.
    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    // Width of one RAM location.
    localparam int BYTE_W = 8;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combines captured RAM bytes into a load result and applies
//               zero/sign extension for byte loads.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import lsu_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              size_i,        // SZ_BYTE or SZ_WORD
    input  logic              sign_i,        // byte loads: 1 = sign-extend
    input  logic [BYTE_W-1:0] first_byte_i,  // byte A (word loads only)
    input  logic [BYTE_W-1:0] cap_byte_i,    // byte A for byte loads, A+1 for words
    output logic [DWIDTH-1:0] data_o
);

    // Select between little-endian word combine and extended byte.
    always_comb begin
        data_o = '0;
        if (size_i == SZ_WORD) begin
            data_o[2*BYTE_W-1:0] = {cap_byte_i, first_byte_i};
        end else if (sign_i) begin
            data_o = {{(DWIDTH-BYTE_W){cap_byte_i[BYTE_W-1]}}, cap_byte_i};
        end else begin
            data_o = {{(DWIDTH-BYTE_W){1'b0}}, cap_byte_i};
        end
    end

endmodule : load_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Sequences one load/store request at a time onto a byte-wide
//               RAM, splitting word accesses into two little-endian byte
//               accesses and returning load data with a one-cycle valid.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic                  req_size_i,
    input  logic                  req_sign_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DWIDTH-1:0]     rsp_rdata_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DWIDTH-1:0]     ram_din_o,
    output logic                  ram_we_o,
    input  logic [DWIDTH-1:0]     ram_dout_i
);

    lsu_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic                  size_q, size_d;
    logic                  sign_q, sign_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0]     wdata_q, wdata_d;
    logic [BYTE_W-1:0]     lo_q, lo_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic [DWIDTH-1:0]     align_data;
    logic [ADDR_WIDTH-1:0] addr_plus1;

    // Only the low byte of the RAM output carries data.
    logic unused_dout_hi;
    assign unused_dout_hi = ^ram_dout_i[DWIDTH-1:BYTE_W];

    // Second byte address; natural wrap modulo 2^ADDR_WIDTH.
    assign addr_plus1 = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    load_align #(
        .DWIDTH (DWIDTH)
    ) u_load_align (
        .size_i       (size_q),
        .sign_i       (sign_q),
        .first_byte_i (lo_q),
        .cap_byte_i   (ram_dout_i[BYTE_W-1:0]),
        .data_o       (align_data)
    );

    // State, request latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            sign_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state logic: accept, byte sequencing, capture and response.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sign_d      = sign_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    sign_d  = req_sign_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (size_q == SZ_WORD) begin
                    state_d = ST_HI;
                end else if (we_q) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = ST_CAP;
                end
            end
            ST_HI: begin
                if (we_q) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    // RAM output now holds byte A, read during LO.
                    lo_d    = ram_dout_i[BYTE_W-1:0];
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                rsp_rdata_d = align_data;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM drive decoded from registered state only.
    always_comb begin
        ram_addr_o = addr_q;
        ram_din_o  = '0;
        ram_we_o   = 1'b0;
        case (state_q)
            ST_LO: begin
                // Write is suppressed while rst is high so a request being
                // reset never commits a further byte.
                ram_we_o = we_q && !rst;
                if (we_q) begin
                    ram_din_o = {{(DWIDTH-BYTE_W){1'b0}}, wdata_q[BYTE_W-1:0]};
                end
            end
            ST_HI: begin
                ram_addr_o = addr_plus1;
                ram_we_o   = we_q && !rst;
                if (we_q) begin
                    ram_din_o = {{(DWIDTH-BYTE_W){1'b0}}, wdata_q[2*BYTE_W-1:BYTE_W]};
                end
            end
            default: begin
                ram_addr_o = addr_q;
            end
        endcase
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule : load_store_unit
`default_nettype wire
